// File: rtl/painterengine_gpu_dvi_rx_if.sv
// rtl/painterengine_gpu_dvi_rx_if.sv - packed pixel output stream between capture and framebuffer writer
interface painterengine_gpu_dvi_rx_if;
  logic [31:0] o_wire_rgba;
  logic        o_wire_valid;
  logic        i_wire_ready;

  modport master (output o_wire_rgba, output o_wire_valid, input i_wire_ready);
  modport slave  (input o_wire_rgba, input o_wire_valid, output i_wire_ready);
endinterface

// File: rtl/painterengine_gpu_dvi_rx.sv
// rtl/painterengine_gpu_dvi_rx.sv - DVI/RGB frame capture into packed RGBA words through an output FIFO
// Defining DVI_RX_MEASURE_EN adds the h/v measurement outputs; otherwise they read 0.
module painterengine_gpu_dvi_rx #(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic        i_wire_pixel_clock,
  input  logic        i_wire_reset,
  input  logic        i_wire_hs,
  input  logic        i_wire_vs,
  input  logic        i_wire_de,
  input  logic [23:0] i_wire_rgb,
  input  logic        i_wire_vs_pol,
  input  logic [2:0]  i_wire_rgba_mode,
  input  logic [15:0] i_wire_clip_width,
  input  logic [15:0] i_wire_clip_height,
  input  logic        i_wire_start,
  painterengine_gpu_dvi_rx_if.master m_stream,
  output logic        o_wire_done,
  output logic        o_wire_error,
  output logic        o_wire_overflow,
  output logic [31:0] o_wire_counter,
  output logic [15:0] o_wire_h_measured,
  output logic [15:0] o_wire_v_measured
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT_VS, S_CAPTURE, S_DONE} state_t;
  state_t state_q, state_d;

  logic        hs_d0, vs_d0, de_d0, de_q, vs_act_q;
  logic [23:0] rgb_d0;
  logic [15:0] x_q, y_q;
  logic        vs_act, frame_edge, de_fall, in_window;
  logic [31:0] target, cnt_next, packed_px;
  logic        clear_flags, set_done, set_error;
  logic        unused_hs;

  assign unused_hs  = hs_d0;
  assign vs_act     = (vs_d0 == i_wire_vs_pol);
  assign frame_edge = vs_act & ~vs_act_q;
  assign de_fall    = ~de_d0 & de_q;
  assign target     = {16'd0, i_wire_clip_width} * {16'd0, i_wire_clip_height};
  assign cnt_next   = o_wire_counter + 32'd1;
  assign in_window  = (state_q == S_CAPTURE) && de_d0 &&
                      (x_q < i_wire_clip_width) && (y_q < i_wire_clip_height);

  always_ff @(posedge i_wire_pixel_clock) begin
    if (i_wire_reset) begin
      hs_d0    <= 1'b0;
      vs_d0    <= 1'b0;
      de_d0    <= 1'b0;
      rgb_d0   <= 24'd0;
      de_q     <= 1'b0;
      vs_act_q <= 1'b0;
      x_q      <= 16'd0;
      y_q      <= 16'd0;
    end else begin
      hs_d0    <= i_wire_hs;
      vs_d0    <= i_wire_vs;
      de_d0    <= i_wire_de;
      rgb_d0   <= i_wire_rgb;
      de_q     <= de_d0;
      vs_act_q <= vs_act;
      x_q      <= de_d0 ? ((x_q == 16'hFFFF) ? x_q : x_q + 16'd1) : 16'd0;
      if (frame_edge)
        y_q <= 16'd0;
      else if (de_fall && y_q != 16'hFFFF)
        y_q <= y_q + 16'd1;
    end
  end

  always_ff @(posedge i_wire_pixel_clock) begin
    if (i_wire_reset) state_q <= S_IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    clear_flags = 1'b0;
    set_done    = 1'b0;
    set_error   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_wire_start) begin
          clear_flags = 1'b1;
          state_d     = S_WAIT_VS;
        end
      end
      S_WAIT_VS: begin
        // an empty window can never be filled, so finish without waiting for video
        if (target == 32'd0) begin
          set_done = 1'b1;
          state_d  = S_DONE;
        end else if (frame_edge) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (in_window && cnt_next == target) begin
          set_done = 1'b1;
          state_d  = S_DONE;
        end else if (frame_edge) begin
          set_done  = 1'b1;
          set_error = 1'b1;
          state_d   = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    packed_px = 32'd0;
    case (i_wire_rgba_mode)
      3'd0: packed_px = {8'hFF, rgb_d0[23:16], rgb_d0[15:8], rgb_d0[7:0]};
      3'd1: packed_px = {rgb_d0[23:16], rgb_d0[15:8], rgb_d0[7:0], 8'hFF};
      3'd2: packed_px = {8'hFF, rgb_d0[7:0], rgb_d0[15:8], rgb_d0[23:16]};
      3'd3: packed_px = {rgb_d0[7:0], rgb_d0[15:8], rgb_d0[23:16], 8'hFF};
      default: packed_px = 32'd0;
    endcase
  end

  logic               px_we;
  logic [31:0]        px_data;
  logic [31:0]        mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full, rd_en, wr_ok, ovf_evt;

  assign full    = count[FIFO_AW];
  assign rd_en   = m_stream.o_wire_valid & m_stream.i_wire_ready;
  assign wr_ok   = px_we & (~full | rd_en);
  assign ovf_evt = px_we & full & ~rd_en;

  assign m_stream.o_wire_valid = (count != '0);
  assign m_stream.o_wire_rgba  = m_stream.o_wire_valid ? mem[rd_ptr] : 32'd0;

  always_ff @(posedge i_wire_pixel_clock) begin
    if (wr_ok) mem[wr_ptr] <= px_data;
  end

  always_ff @(posedge i_wire_pixel_clock) begin
    if (i_wire_reset) begin
      px_we   <= 1'b0;
      px_data <= 32'd0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      px_we   <= in_window;
      px_data <= packed_px;
      if (wr_ok) wr_ptr <= wr_ptr + {{(FIFO_AW-1){1'b0}}, 1'b1};
      if (rd_en) rd_ptr <= rd_ptr + {{(FIFO_AW-1){1'b0}}, 1'b1};
      case ({wr_ok, rd_en})
        2'b10:   count <= count + {{FIFO_AW{1'b0}}, 1'b1};
        2'b01:   count <= count - {{FIFO_AW{1'b0}}, 1'b1};
        default: count <= count;
      endcase
    end
  end

  // counter keeps counting dropped pixels: it reports what the window saw, not what was kept
  always_ff @(posedge i_wire_pixel_clock) begin
    if (i_wire_reset || clear_flags) begin
      o_wire_done     <= 1'b0;
      o_wire_error    <= 1'b0;
      o_wire_overflow <= 1'b0;
      o_wire_counter  <= 32'd0;
    end else begin
      if (set_done)  o_wire_done     <= 1'b1;
      if (set_error) o_wire_error    <= 1'b1;
      if (ovf_evt)   o_wire_overflow <= 1'b1;
      if (in_window) o_wire_counter  <= cnt_next;
    end
  end

`ifdef DVI_RX_MEASURE_EN
  logic [15:0] h_meas_q, v_meas_q;
  always_ff @(posedge i_wire_pixel_clock) begin
    if (i_wire_reset) begin
      h_meas_q <= 16'd0;
      v_meas_q <= 16'd0;
    end else begin
      if (de_fall)    h_meas_q <= x_q;
      if (frame_edge) v_meas_q <= y_q;
    end
  end
  assign o_wire_h_measured = h_meas_q;
  assign o_wire_v_measured = v_meas_q;
`else
  assign o_wire_h_measured = 16'd0;
  assign o_wire_v_measured = 16'd0;
`endif
endmodule

// File: tb/tb_painterengine_gpu_dvi_rx.sv
// tb/tb_painterengine_gpu_dvi_rx.sv - directed and randomized frame captures checked against a pixel-list model
module tb_painterengine_gpu_dvi_rx;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hs = 1'b0, vs = 1'b0, de = 1'b0, start = 1'b0, pol = 1'b1;
  logic [23:0] rgb = 24'd0;
  logic [2:0]  mode = 3'd0;
  logic [15:0] cw = 16'd0, ch = 16'd0;
  logic        done, error, ovf;
  logic [31:0] counter;
  logic [15:0] h_meas, v_meas;

  int checks = 0;
  int errors = 0;
  int ready_mode = 1;
  bit armed = 0;
  bit seen_valid = 0;
  int model_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  painterengine_gpu_dvi_rx_if ifc ();

  painterengine_gpu_dvi_rx dut (
    .i_wire_pixel_clock (clk),
    .i_wire_reset       (rst),
    .i_wire_hs          (hs),
    .i_wire_vs          (vs),
    .i_wire_de          (de),
    .i_wire_rgb         (rgb),
    .i_wire_vs_pol      (pol),
    .i_wire_rgba_mode   (mode),
    .i_wire_clip_width  (cw),
    .i_wire_clip_height (ch),
    .i_wire_start       (start),
    .m_stream           (ifc),
    .o_wire_done        (done),
    .o_wire_error       (error),
    .o_wire_overflow    (ovf),
    .o_wire_counter     (counter),
    .o_wire_h_measured  (h_meas),
    .o_wire_v_measured  (v_meas)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && ifc.o_wire_valid) seen_valid = 1'b1;
    if (!rst && ifc.o_wire_valid && ifc.i_wire_ready) got_q.push_back(ifc.o_wire_rgba);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] pack(input logic [2:0] m, input logic [23:0] c);
    logic [7:0] r, g, b;
    r = c[23:16];
    g = c[15:8];
    b = c[7:0];
    case (m)
      3'd0:    return {8'hFF, r, g, b};
      3'd1:    return {r, g, b, 8'hFF};
      3'd2:    return {8'hFF, b, g, r};
      3'd3:    return {b, g, r, 8'hFF};
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive(input bit vsa, input bit hsv, input bit dev, input logic [23:0] c);
    vs  = vsa ? pol : ~pol;
    hs  = hsv;
    de  = dev;
    rgb = c;
    case (ready_mode)
      0:       ifc.i_wire_ready = 1'b0;
      1:       ifc.i_wire_ready = 1'b1;
      default: ifc.i_wire_ready = dev ? 1'($urandom_range(0, 1)) : 1'b1;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 24'd0);
  endtask

  task automatic do_start();
    exp_q.delete();
    got_q.delete();
    model_cnt  = 0;
    seen_valid = 0;
    armed      = (cw != 16'd0) && (ch != 16'd0);
    start      = 1'b1;
    idle(1);
    start      = 1'b0;
  endtask

  task automatic send_frame(input int w, input int lines, input int src);
    logic [23:0] c;
    idle(3);
    repeat (2) drive(1'b1, 1'b0, 1'b0, 24'd0);
    idle(4);
    for (int y = 0; y < lines; y++) begin
      for (int x = 0; x < w; x++) begin
        c = (src == 1) ? 24'h123456 : (src == 2) ? 24'(x) : 24'($urandom);
        if (armed && x < int'(cw) && y < int'(ch)) begin
          exp_q.push_back(pack(mode, c));
          model_cnt++;
        end
        drive(1'b0, 1'b0, 1'b1, c);
      end
      for (int i = 0; i < 24; i++) drive(1'b0, (i >= 2 && i < 6), 1'b0, 24'd0);
    end
    armed = 0;
  endtask

  task automatic close_frame();
    repeat (2) drive(1'b1, 1'b0, 1'b0, 24'd0);
    idle(4);
  endtask

  task automatic drain_and_compare(input string tag);
    ready_mode = 1;
    for (int i = 0; i < 64; i++) begin
      if (!ifc.o_wire_valid) break;
      idle(1);
    end
    check({tag, "_drained"}, 32'(ifc.o_wire_valid), 32'd0);
    check({tag, "_nwords"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_word"}, got_q[i], exp_q[i]);
  endtask

  task automatic run_frame(input string tag, input int w, input int h, input int src, input bit fits);
    do_start();
    send_frame(w, h, src);
    check({tag, "_done_pre"}, 32'(done), 32'(fits));
    close_frame();
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_error"}, 32'(error), 32'(!fits));
    check({tag, "_counter"}, counter, model_cnt);
    check({tag, "_overflow"}, 32'(ovf), 32'd0);
    drain_and_compare(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_ovf"}, 32'(ovf), 32'd0);
    check({tag, "_counter"}, counter, 32'd0);
    check({tag, "_valid"}, 32'(ifc.o_wire_valid), 32'd0);
    check({tag, "_rgba"}, ifc.o_wire_rgba, 32'd0);
    check({tag, "_hmeas"}, 32'(h_meas), 32'd0);
    check({tag, "_vmeas"}, 32'(v_meas), 32'd0);
  endtask

  initial begin
    int w, h;
    bit fits;
    ifc.i_wire_ready = 1'b1;
    vs = ~pol;
    idle(3);
    check_all_zero("reset");
    rst = 1'b0;
    idle(4);

    // full window, constant colour, ARGB
    cw = 16'd16; ch = 16'd4; mode = 3'd0; ready_mode = 1;
    run_frame("full", 16, 4, 1, 1'b1);
`ifdef DVI_RX_MEASURE_EN
    check("meas_h", 32'(h_meas), 32'd16);
    check("meas_v", 32'(v_meas), 32'd4);
`else
    check("meas_h", 32'(h_meas), 32'd0);
    check("meas_v", 32'(v_meas), 32'd0);
`endif

    // small corner window, BGRA, rgb carries the x index
    cw = 16'd4; ch = 16'd2; mode = 3'd3;
    run_frame("clip4x2", 16, 4, 2, 1'b1);

    // consumer stalled for the whole capture: FIFO keeps the first entries only
    cw = 16'd32; ch = 16'd1; mode = 3'd1; ready_mode = 0;
    do_start();
    send_frame(40, 2, 0);
    check("ovf_flag", 32'(ovf), 32'd1);
    check("ovf_counter", counter, 32'd32);
    check("ovf_done", 32'(done), 32'd1);
    check("ovf_none_yet", got_q.size(), 32'd0);
    while (exp_q.size() > 16) void'(exp_q.pop_back());
    drain_and_compare("ovf");

    // window larger than source: next frame edge ends it with error
    cw = 16'd14; ch = 16'd4; mode = 3'd2; ready_mode = 1;
    run_frame("oversize", 12, 3, 0, 1'b0);

    // zero-width window completes immediately
    cw = 16'd0; ch = 16'd10; mode = 3'd0;
    do_start();
    check("zero_done_early", 32'(done), 32'd0);
    idle(1);
    check("zero_done", 32'(done), 32'd1);
    check("zero_counter", counter, 32'd0);
    send_frame(16, 2, 0);
    close_frame();
    check("zero_no_valid", 32'(seen_valid), 32'd0);
    check("zero_error", 32'(error), 32'd0);

    // randomized sources, windows, modes, sync polarity and consumer stalls
    for (int k = 0; k < 8; k++) begin
      w    = $urandom_range(8, 16);
      h    = $urandom_range(2, 5);
      cw   = 16'($urandom_range(1, 14));
      ch   = 16'($urandom_range(1, h + 1));
      mode = 3'($urandom_range(0, 7));
      pol  = 1'($urandom_range(0, 1));
      ready_mode = 2;
      idle(4);
      fits = (int'(cw) <= w) && (int'(ch) <= h);
      run_frame($sformatf("rand%0d", k), w, h, 0, fits);
    end

    // reset in the middle of a stalled capture
    pol = 1'b1; cw = 16'd16; ch = 16'd4; mode = 3'd0; ready_mode = 0;
    idle(4);
    do_start();
    send_frame(16, 2, 0);
    check("midrst_ovf_before", 32'(ovf), 32'd1);
    check("midrst_cnt_before", counter, 32'd32);
    rst = 1'b1;
    idle(1);
    check_all_zero("midrst");
    rst = 1'b0;
    ready_mode = 1;
    idle(3);
    check("midrst_stays_empty", 32'(ifc.o_wire_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/painterengine_gpu_dvi_rx.md
Name: painterengine_gpu_dvi_rx

Overview:
- Capture-side counterpart of the GPU DVI output stage.
- Samples a parallel DVI/RGB stream (hs, vs, de, 24-bit rgb), tracks pixel position, and clips to a configured window.
- Packs each in-window pixel into 32-bit words in the selected RGBA byte order and pushes them through a small FIFO to a ready/valid consumer (framebuffer writer).
- Captures one frame per start request and reports done, error and overflow status.

Parameters:
- FIFO_DEPTH, 16, output FIFO entries; power of two, minimum 4.
- FIFO_AW, 4, log2(FIFO_DEPTH).

Ports:
- i_wire_pixel_clock  in  1  pixel clock; all logic on its rising edge.
- i_wire_reset  in  1  synchronous, active-high reset.
- i_wire_hs  in  1  horizontal sync from source.
- i_wire_vs  in  1  vertical sync from source.
- i_wire_de  in  1  data enable from source.
- i_wire_rgb  in  24  {r[23:16], g[15:8], b[7:0]}.
- i_wire_vs_pol  in  1  active level of vs.
- i_wire_rgba_mode  in  3  0=ARGB, 1=RGBA, 2=ABGR, 3=BGRA.
- i_wire_clip_width  in  16  window width in pixels.
- i_wire_clip_height  in  16  window height in lines.
- i_wire_start  in  1  one-cycle pulse; arms capture of the next frame.
- o_wire_rgba  out  32  packed pixel at FIFO head.
- o_wire_valid  out  1  o_wire_rgba valid.
- i_wire_ready  in  1  consumer accepts word when valid&&ready.
- o_wire_done  out  1  sticky; frame capture complete.
- o_wire_error  out  1  sticky; frame ended before window filled.
- o_wire_overflow  out  1  sticky; pixel dropped on FIFO full.
- o_wire_counter  out  32  in-window pixels seen this capture.
- o_wire_h_measured  out  16  de-high length of last line (optional feature).
- o_wire_v_measured  out  16  de lines in last full frame (optional feature).

Behaviour:
- Reset: all outputs 0; FIFO empty; state IDLE.
- Input stage: hs/vs/de/rgb registered once (stage d0); all decisions use d0 values.
- vs_act = (vs_d0 == i_wire_vs_pol). Frame edge = vs_act rising (vs_act now 1, previous 0).
- Positions:
  - x: increments on each de_d0-high cycle; cleared to 0 on de_d0 low.
  - y: increments on each de_d0 falling edge; cleared on frame edge.
  - x and y are 16-bit and saturate at 0xFFFF.
- In-window pixel: state CAPTURE && de_d0 && x < clip_width && y < clip_height.
- Packing (alpha byte = 8'hFF):
  - ARGB = {FF,r,g,b}; RGBA = {r,g,b,FF}; ABGR = {FF,b,g,r}; BGRA = {b,g,r,FF}.
  - Modes 4–7 pack 32'h0.
- State machine:
  - IDLE: on i_wire_start → clear done/error/overflow/counter, go WAIT_VS.
  - WAIT_VS: on frame edge → CAPTURE.
  - Zero window: if clip_width==0 or clip_height==0 at start, go straight to DONE next cycle, done=1, counter=0.
  - CAPTURE: each in-window pixel increments counter (32-bit; product compared at 32 bits).
    - When counter reaches clip_width*clip_height → DONE.
    - Frame edge before that → DONE with error=1.
  - DONE: done held; i_wire_start → restart as from IDLE.
  - i_wire_start in WAIT_VS or CAPTURE is ignored.
- FIFO:
  - In-window pixel written the cycle after d0 capture. Latency: pin sample edge N → d0 at N → FIFO write at N+1 → o_wire_valid high after N+2 when FIFO was empty.
  - Full at write time: pixel dropped, overflow=1, counter still increments.
  - Simultaneous write and read at full is allowed (read frees the slot).
  - o_wire_rgba is stable while valid && !ready.
  - FIFO keeps draining in DONE. done asserts at the counter condition, not on FIFO empty.
- Reset mid-capture: FIFO flushed, all flags and counters cleared, state IDLE.

Optional Feature:
- DVI_RX_MEASURE_EN defined:
  - o_wire_h_measured latches x at each de_d0 falling edge.
  - At each frame edge, o_wire_v_measured latches the y value from before the clear.
  - Both update in every state, including IDLE.
- Undefined: both outputs tied to 16'd0 and the measurement logic is absent.

Test Plan:
1. 640x480 source, clip 640x480, ARGB, ready=1, pixel rgb=24'h123456 → 307200 words of 32'hFF123456, done=1, error=0, counter=307200.
2. 640x480 source, clip 4x2, BGRA, rgb = x-index → exactly 8 words {b,g,r,FF}, only x<4 on lines 0–1; done after the 8th pixel.
3. ready=0 for a whole line, clip 32x1, FIFO_DEPTH=16 → 16 words retained, overflow=1, counter=32; then ready=1 drains exactly 16 words.
4. Clip 800x600 on 640x480 source → the next frame edge sets done=1, error=1, counter=307200.
5. Clip 0x10 plus start pulse → done=1 two cycles later, no valid ever asserted; vs_pol=1 vs 0 with inverted vs gives identical output.
6. Reset pulse mid-CAPTURE → all outputs 0 the next cycle. With DVI_RX_MEASURE_EN on a 640x480 source: h_measured=640, v_measured=480.
